mcp_sched: RTL
==============

# mcp_sched

Multi-cycle-path launch scheduler. Arbitrates NREQ requesters for one shared launch register, loads the doubled request word, and holds it stable for HOLD_CYC cycles. It then pulses a one-cycle capture enable to the destination domain logic and returns a done pulse to the winning requester. It sits in front of every MCP-constrained transfer, so the destination register is only ever enabled when its input is known stable.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, request data width
- HOLD_CYC, 2, cycles mcp_data is stable before mcp_en asserts (1..15)
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; held until matching done
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, high for the whole transfer
- done  out  NREQ  one-cycle completion pulse to the granted requester
- mcp_data  out  DW+1  launch register driven to the MCP destination
- mcp_en  out  1  one-cycle capture enable for the destination register
- busy  out  1  high in any state other than IDLE

## Operation
- Reset values are all zero: gnt, done, mcp_data, mcp_en, busy, hold counter and round-robin pointer. The FSM resets to IDLE.
- The FSM has four states, IDLE, HOLD, CAPT and DONE, all registered.
- IDLE: if any req bit is high, the arbiter picks index g. The FSM then:
  - sets gnt = 1<<g;
  - loads mcp_data = zero-extended req_data[g] + zero-extended req_data[g], computed at DW+1 bits so it cannot overflow;
  - loads the counter with HOLD_CYC-1;
  - moves to HOLD.
- HOLD: while the counter is non-zero it decrements, and mcp_data is not written. When the counter is 0, the FSM moves to CAPT.
- CAPT: mcp_en = 1 for exactly this one state, then the FSM moves to DONE.
- DONE: done[g] = 1 for one cycle, gnt clears, then the FSM moves to IDLE.
- mcp_data keeps its last value after the transfer and is only rewritten at the next grant.
- A requester that drops req mid-transfer is ignored: the transfer completes and done still pulses.
- A requester that holds req after done is treated as a new request.
- Simultaneous requests: exactly one grant is made. The others wait with no loss of their requests.
- Asserting reset_n low mid-transfer clears every output at once, and no done is issued for the aborted transfer.

## Timing
- Edge k: req is sampled high in IDLE.
- Edge k+1: gnt, busy and mcp_data become valid.
- Edge k+1+HOLD_CYC: mcp_en rises. mcp_data has been stable for HOLD_CYC full cycles.
- Edge k+2+HOLD_CYC: mcp_en falls, done[g] rises and gnt falls.
- Edge k+3+HOLD_CYC: done falls, busy falls and IDLE is re-entered. A pending request is sampled at this edge.
- Grant-to-grant spacing is HOLD_CYC+3 cycles. With the default HOLD_CYC = 2 that is 5 cycles.
- No combinational path runs from any input to any output.

## Configuration
- MCP_SCHED_RR_EN defined:
  - round-robin arbitration;
  - the pointer starts at 0;
  - after granting g, the highest priority becomes (g+1) mod NREQ;
  - the pointer updates only on a grant.
- Not defined: fixed priority, lowest index wins, and the pointer logic is removed.
- Everything else in the block is identical in both builds.

## Structure
- Shared package mcp_pkg holds:
  - the state typedef (IDLE, HOLD, CAPT, DONE);
  - the counter width constant, 4 bits;
  - the HOLD_CYC legal-range constants checked at elaboration.
- Sub-module mcp_rr_arb takes req and ptr and returns a one-hot grant plus its index. It contains both arbitration variants under MCP_SCHED_RR_EN.

## Test plan
- Reset: hold reset_n low, then release. All outputs read 0 and busy reads 0. Assert reset_n low at edge 3 of a transfer: outputs clear at once and done never pulses.
- Single transfer, HOLD_CYC=2:
  - stimulus: req=0001, req_data[0]=8'hC8, req sampled at edge 0;
  - response: gnt=0001 and mcp_data=9'h190 at edge 1, mcp_en high for cycle 3-4 only, done=0001 high for cycle 4-5 only.
- Stability: across the interval from edge 1 to edge 4, change req_data[0] every cycle. mcp_data must stay 9'h190.
- Round robin (MCP_SCHED_RR_EN): hold req=1111. The grant order is 0,1,2,3,0 with 5-cycle spacing.
- Fixed priority (macro undefined): hold req=0110. Requester 1 is granted repeatedly and requester 2 is never granted.
- Request withdrawal: drop req[2] one cycle after its grant. done[2] still pulses, and the next grant goes to another pending requester.

Source files
------------

// File: rtl/mcp_sched_pkg.sv
// mcp_pkg: shared types and constants for the MCP launch scheduler.
//   mcp_state_e  - scheduler FSM states (IDLE, HOLD, CAPT, DONE)
//   CNT_W        - width of the hold counter
//   HOLD_MIN/MAX - legal HOLD_CYC range, checked when mcp_sched elaborates
package mcp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } mcp_state_e;

    localparam int CNT_W    = 4;
    localparam int HOLD_MIN = 1;
    localparam int HOLD_MAX = 15;

endpackage

// File: rtl/mcp_sched_if.sv
// mcp_sched_if: requester/destination bundle of the MCP launch scheduler.
//   req       requester levels, held until the matching done
//   req_data  requester i data at [i*DW +: DW]
//   gnt       one-hot grant, high for the whole transfer
//   done      one-cycle completion pulse to the granted requester
//   mcp_data  launch register toward the MCP destination (DW+1 bits)
//   mcp_en    one-cycle capture enable for the destination register
//   busy      scheduler not idle
// Modports: master = requester/destination side, slave = scheduler.
interface mcp_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW:0]        mcp_data;
    logic               mcp_en;
    logic               busy;

    modport master (output req, req_data, input gnt, done, mcp_data, mcp_en, busy);
    modport slave  (input req, req_data, output gnt, done, mcp_data, mcp_en, busy);
endinterface

// File: rtl/mcp_sched_arb.sv
// mcp_rr_arb: purely combinational requester arbiter.
//   req  - request vector
//   ptr  - highest-priority index (present only with MCP_SCHED_RR_EN)
//   gnt  - one-hot winner (all zero when req is zero)
//   idx  - binary index of the winner
// Build option MCP_SCHED_RR_EN: round robin starting at ptr.
// Without it: fixed priority, lowest index wins, no ptr port.
module mcp_rr_arb #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
`ifdef MCP_SCHED_RR_EN
    input  logic [PW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

`ifdef MCP_SCHED_RR_EN
    logic found;
    int   j;

    // Scan NREQ positions starting at ptr, wrapping modulo NREQ.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end
`else
    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = PW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mcp_sched.sv
// mcp_sched: multi-cycle-path launch scheduler.
// Arbitrates NREQ requesters for one launch register, loads 2*req_data[g]
// (DW+1 bits, cannot overflow), holds it HOLD_CYC cycles, pulses mcp_en for
// one cycle, then pulses done[g]. All outputs are registered.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mcp_sched_if.slave (req, req_data in; gnt, done, mcp_data,
//            mcp_en, busy out)
// Build option MCP_SCHED_RR_EN: round-robin arbitration; otherwise fixed
// priority (lowest index) with no pointer.
module mcp_sched
    import mcp_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    mcp_sched_if.slave  bus
);

    localparam int PW = $clog2(NREQ);

    generate
        if (HOLD_CYC < HOLD_MIN || HOLD_CYC > HOLD_MAX) begin : g_bad_hold
            $error("mcp_sched: HOLD_CYC out of range");
        end
    endgenerate

    mcp_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]    req_q;
    logic [NREQ*DW-1:0] req_data_q;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [DW:0]        data_q, data_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;

    logic [NREQ-1:0]    arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic [DW-1:0]      win_data;
    logic               launch;

`ifdef MCP_SCHED_RR_EN
    logic [PW-1:0]      ptr_q, ptr_d;
`endif

    // Requests are registered first: the FSM arbitrates on the value seen at
    // the previous edge, which keeps inputs off any output path and gives
    // HOLD_CYC+3 cycles from one grant to the next.
    mcp_rr_arb #(.NREQ(NREQ)) u_arb (
        .req (req_q),
`ifdef MCP_SCHED_RR_EN
        .ptr (ptr_q),
`endif
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign win_data = req_data_q[arb_idx*DW +: DW];
    assign launch   = (state_q == IDLE) && (|req_q);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = HOLD;
            HOLD:    if (cnt_q == '0) state_d = CAPT;
            CAPT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs / datapath
    always_comb begin
        cnt_d  = cnt_q;
        gnt_d  = gnt_q;
        data_d = data_q;
        done_d = '0;
        en_d   = 1'b0;
`ifdef MCP_SCHED_RR_EN
        ptr_d  = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (launch) begin
                    gnt_d  = arb_gnt;
                    data_d = {1'b0, win_data} + {1'b0, win_data};
                    cnt_d  = CNT_W'(HOLD_CYC - 1);
`ifdef MCP_SCHED_RR_EN
                    ptr_d  = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
`endif
                end
            end
            HOLD: begin
                // mcp_en is registered, so it rises on the edge leaving HOLD
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             en_d  = 1'b1;
            end
            CAPT: begin
                done_d = gnt_q;
                gnt_d  = '0;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            req_q      <= '0;
            req_data_q <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            req_q      <= bus.req;
            req_data_q <= bus.req_data;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            data_q     <= data_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
        end
    end

`ifdef MCP_SCHED_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`endif

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.mcp_data = data_q;
    assign bus.mcp_en   = en_q;
    assign bus.busy     = busy_q;

endmodule
